// File: rtl/vec_table_loader_pkg.sv
// Shared constants and state encoding for the boot vector-table loader.
// Frame layout: 80 payload bytes (20 little-endian words) plus one checksum byte.
package vec_loader_pkg;

    localparam int FRAME_BYTES = 81;
    localparam int NUM_VEC     = 20;
    localparam int CNT_W       = 7;

    localparam int SP_IDX    = 0;
    localparam int RESET_IDX = 1;
    localparam int NMI_IDX   = 2;
    localparam int FAULT_IDX = 3;
    localparam int IRQ0_IDX  = 4;

    localparam logic [3:0] LOAD  = 4'b0001;
    localparam logic [3:0] DRAIN = 4'b0010;
    localparam logic [3:0] DONE  = 4'b0100;
    localparam logic [3:0] FAIL  = 4'b1000;

    typedef enum logic [3:0] {
        ST_LOAD  = LOAD,
        ST_DRAIN = DRAIN,
        ST_DONE  = DONE,
        ST_FAIL  = FAIL
    } state_e;

endpackage

// File: rtl/vec_table_loader_if.sv
// Byte-stream handshake from the key/boot store into the vector-table loader.
interface vec_table_loader_if;

    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);

endinterface

// File: rtl/vec_table_loader_frame_ctr.sv
// Byte position and running checksum of the frame currently being loaded,
// with detection of good, short, overlong and bad-checksum frames.
module vec_frame_ctr
    import vec_loader_pkg::*;
(
    input  logic             hclk,
    input  logic             hreset,
    input  logic             accept_i,
    input  logic [7:0]       data_i,
    input  logic             last_i,
    output logic [CNT_W-1:0] byte_cnt_o,
    output logic             frame_ok_o,
    output logic             frame_err_o,
    output logic             overlong_o
);

    logic [CNT_W-1:0] byte_cnt_q;
    logic [7:0]       sum_q;
    logic [7:0]       sum_d;
    logic             at_cksum;
    logic             sum_zero;

    assign sum_d      = sum_q + data_i;
    assign at_cksum   = (byte_cnt_q == CNT_W'(FRAME_BYTES - 1));
    assign sum_zero   = (sum_d == 8'h00);
    assign byte_cnt_o = byte_cnt_q;

    // Only the checksum byte can complete a frame; s_last anywhere earlier is a short frame.
    assign frame_ok_o  = accept_i & at_cksum & last_i & sum_zero;
    assign overlong_o  = accept_i & at_cksum & ~last_i;
    assign frame_err_o = accept_i & ((at_cksum & ~(last_i & sum_zero)) | (~at_cksum & last_i));

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            byte_cnt_q <= '0;
            sum_q      <= '0;
        end else if (accept_i) begin
            if (frame_ok_o || frame_err_o) begin
                byte_cnt_q <= '0;
                sum_q      <= '0;
            end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
                sum_q      <= sum_d;
            end
        end
    end

endmodule

// File: rtl/vec_table_loader.sv
// Loads the boot vector table from a checksummed byte stream, holds the CPU in
// reset until a frame verifies, and locks out after MAX_RETRY rejected frames.
module vec_table_loader
    import vec_loader_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic                hclk,
    input  logic                hreset,
    vec_table_loader_if.slave   s,
    output logic [31:0]         sp_addr,
    output logic [31:0]         reset_addr,
    output logic [31:0]         nmi_addr,
    output logic [31:0]         fault_addr,
    output logic [31:0]         irq0_addr,
    output logic [31:0]         irq1_addr,
    output logic [31:0]         irq2_addr,
    output logic [31:0]         irq3_addr,
    output logic [31:0]         irq4_addr,
    output logic [31:0]         irq5_addr,
    output logic [31:0]         irq6_addr,
    output logic [31:0]         irq7_addr,
    output logic [31:0]         irq8_addr,
    output logic [31:0]         irq9_addr,
    output logic [31:0]         irq10_addr,
    output logic [31:0]         irq11_addr,
    output logic [31:0]         irq12_addr,
    output logic [31:0]         irq13_addr,
    output logic [31:0]         irq14_addr,
    output logic [31:0]         irq15_addr,
    output logic                table_valid,
    output logic                cpu_hold,
    output logic                load_err,
    output logic                load_fail,
    output logic [3:0]          fail_cnt
);

    state_e           state_q;
    logic [31:0]      word_q [NUM_VEC];
    logic [31:0]      vec_gated [NUM_VEC];
    logic             table_valid_q;
    logic             cpu_hold_q;
    logic             load_err_q;
    logic             load_fail_q;
    logic             s_ready_q;
    logic [3:0]       fail_cnt_q;
    logic [3:0]       fail_cnt_d;
    logic             handshake;
    logic             accept;
    logic [CNT_W-1:0] byte_cnt;
    logic             frame_ok;
    logic             frame_err;
    logic             overlong;

    assign handshake  = s.s_valid & s_ready_q;
    assign accept     = handshake & (state_q == ST_LOAD);
    assign fail_cnt_d = fail_cnt_q + 4'd1;

    vec_frame_ctr u_ctr (
        .hclk        (hclk),
        .hreset      (hreset),
        .accept_i    (accept),
        .data_i      (s.s_data),
        .last_i      (s.s_last),
        .byte_cnt_o  (byte_cnt),
        .frame_ok_o  (frame_ok),
        .frame_err_o (frame_err),
        .overlong_o  (overlong)
    );

    // s_ready is registered from the next state so it never depends on s_valid.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q       <= ST_LOAD;
            word_q        <= '{default: '0};
            table_valid_q <= 1'b0;
            cpu_hold_q    <= 1'b1;
            load_err_q    <= 1'b0;
            load_fail_q   <= 1'b0;
            s_ready_q     <= 1'b1;
            fail_cnt_q    <= '0;
        end else begin
            load_err_q <= 1'b0;
            unique case (state_q)
                ST_LOAD: begin
                    if (accept && byte_cnt < CNT_W'(FRAME_BYTES - 1))
                        word_q[byte_cnt[6:2]][{byte_cnt[1:0], 3'b000} +: 8] <= s.s_data;
                    if (frame_ok) begin
                        state_q       <= ST_DONE;
                        table_valid_q <= 1'b1;
                        cpu_hold_q    <= 1'b0;
                        s_ready_q     <= 1'b0;
                    end else if (frame_err) begin
                        load_err_q <= 1'b1;
                        fail_cnt_q <= fail_cnt_d;
                        if (fail_cnt_d == 4'(MAX_RETRY)) begin
                            state_q     <= ST_FAIL;
                            load_fail_q <= 1'b1;
                            s_ready_q   <= 1'b0;
                        end else if (overlong) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (handshake && s.s_last)
                        state_q <= ST_LOAD;
                end
                ST_DONE, ST_FAIL: begin
                end
                default: begin
                    state_q   <= ST_FAIL;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Downstream only ever sees a verified table, never partial staging contents.
    always_comb begin
        for (int i = 0; i < NUM_VEC; i++)
            vec_gated[i] = table_valid_q ? word_q[i] : 32'h0;
    end

    assign sp_addr    = vec_gated[SP_IDX];
    assign reset_addr = vec_gated[RESET_IDX];
    assign nmi_addr   = vec_gated[NMI_IDX];
    assign fault_addr = vec_gated[FAULT_IDX];
    assign irq0_addr  = vec_gated[IRQ0_IDX + 0];
    assign irq1_addr  = vec_gated[IRQ0_IDX + 1];
    assign irq2_addr  = vec_gated[IRQ0_IDX + 2];
    assign irq3_addr  = vec_gated[IRQ0_IDX + 3];
    assign irq4_addr  = vec_gated[IRQ0_IDX + 4];
    assign irq5_addr  = vec_gated[IRQ0_IDX + 5];
    assign irq6_addr  = vec_gated[IRQ0_IDX + 6];
    assign irq7_addr  = vec_gated[IRQ0_IDX + 7];
    assign irq8_addr  = vec_gated[IRQ0_IDX + 8];
    assign irq9_addr  = vec_gated[IRQ0_IDX + 9];
    assign irq10_addr = vec_gated[IRQ0_IDX + 10];
    assign irq11_addr = vec_gated[IRQ0_IDX + 11];
    assign irq12_addr = vec_gated[IRQ0_IDX + 12];
    assign irq13_addr = vec_gated[IRQ0_IDX + 13];
    assign irq14_addr = vec_gated[IRQ0_IDX + 14];
    assign irq15_addr = vec_gated[IRQ0_IDX + 15];

    assign table_valid = table_valid_q;
    assign cpu_hold    = cpu_hold_q;
    assign load_err    = load_err_q;
    assign load_fail   = load_fail_q;
    assign fail_cnt    = fail_cnt_q;
    assign s.s_ready   = s_ready_q;

endmodule

// File: tb/tb_vec_table_loader.sv
// Directed bench for vec_table_loader: good, bad-checksum, short, overlong,
// retry exhaustion, mid-frame reset and gapped-stream frames.
module tb_vec_table_loader;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] vecOut [20];
    logic        tableValid, cpuHold, loadErr, loadFail;
    logic [3:0]  failCnt;
    logic [31:0] goodWords [20];
    logic [7:0]  frameBuf [96];
    int          compareCount = 0;
    int          mismatchCount = 0;

    vec_table_loader_if bus ();

    vec_table_loader #(.MAX_RETRY(3)) dut (
        .hclk(hclk), .hreset(hreset), .s(bus),
        .sp_addr(vecOut[0]), .reset_addr(vecOut[1]), .nmi_addr(vecOut[2]), .fault_addr(vecOut[3]),
        .irq0_addr(vecOut[4]), .irq1_addr(vecOut[5]), .irq2_addr(vecOut[6]), .irq3_addr(vecOut[7]),
        .irq4_addr(vecOut[8]), .irq5_addr(vecOut[9]), .irq6_addr(vecOut[10]), .irq7_addr(vecOut[11]),
        .irq8_addr(vecOut[12]), .irq9_addr(vecOut[13]), .irq10_addr(vecOut[14]), .irq11_addr(vecOut[15]),
        .irq12_addr(vecOut[16]), .irq13_addr(vecOut[17]), .irq14_addr(vecOut[18]), .irq15_addr(vecOut[19]),
        .table_valid(tableValid), .cpu_hold(cpuHold), .load_err(loadErr),
        .load_fail(loadFail), .fail_cnt(failCnt)
    );

    always #5 hclk = ~hclk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyReset();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        hreset      = 1'b1;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
    endtask

    // Words 0,1 and 19 are the named test values; the rest follow i*0x01010101.
    task automatic buildFrame(input logic [7:0] cksumXor);
        logic [7:0] sum;
        sum = 8'h00;
        for (int w = 0; w < 20; w++)
            for (int l = 0; l < 4; l++) begin
                frameBuf[w*4+l] = goodWords[w][l*8 +: 8];
                sum += goodWords[w][l*8 +: 8];
            end
        frameBuf[80] = (8'h00 - sum) ^ cksumXor;
        for (int i = 81; i < 96; i++) frameBuf[i] = 8'(i * 3);
    endtask

    task automatic applyStimulus(input int first, input int last, input int lastIdx, input int idlePct);
        logic rdy;
        logic done;
        for (int i = first; i <= last; i++) begin
            if (idlePct > 0 && $urandom_range(99) < idlePct) begin
                bus.s_valid = 1'b0;
                @(posedge hclk);
                #1;
            end
            bus.s_valid = 1'b1;
            bus.s_data  = frameBuf[i];
            bus.s_last  = (i == lastIdx);
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
                rdy = bus.s_ready;
                @(posedge hclk);
                #1;
                done = rdy;
            end
            if (!done) checkOutput("handshakeTimeout", 32'(i), 32'hFFFF_FFFF);
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
        end
    endtask

    task automatic checkGoodTable(input string tag);
        checkOutput({tag, "_valid"}, 32'(tableValid), 32'd1);
        checkOutput({tag, "_hold"}, 32'(cpuHold), 32'd0);
        checkOutput({tag, "_sp"}, vecOut[0], 32'h2000_4000);
        checkOutput({tag, "_reset"}, vecOut[1], 32'h0000_0101);
        checkOutput({tag, "_fault"}, vecOut[3], 32'h0303_0303);
        checkOutput({tag, "_irq15"}, vecOut[19], 32'hDEAD_BEEF);
    endtask

    initial begin
        int errPulses;
        for (int i = 0; i < 20; i++) goodWords[i] = 32'(i) * 32'h0101_0101;
        goodWords[0]  = 32'h2000_4000;
        goodWords[1]  = 32'h0000_0101;
        goodWords[19] = 32'hDEAD_BEEF;

        applyReset();
        checkOutput("rstValid", 32'(tableValid), 32'd0);
        checkOutput("rstHold", 32'(cpuHold), 32'd1);
        checkOutput("rstReady", 32'(bus.s_ready), 32'd1);
        checkOutput("rstErr", 32'(loadErr), 32'd0);
        checkOutput("rstFail", 32'(loadFail), 32'd0);
        checkOutput("rstCnt", 32'(failCnt), 32'd0);
        checkOutput("rstSp", vecOut[0], 32'h0);

        buildFrame(8'h00);
        applyStimulus(0, 79, 80, 0);
        checkOutput("goodPreValid", 32'(tableValid), 32'd0);
        checkOutput("goodPreHold", 32'(cpuHold), 32'd1);
        applyStimulus(80, 80, 80, 0);
        checkGoodTable("good");
        checkOutput("goodNmi", vecOut[2], 32'h0202_0202);
        checkOutput("goodIrq0", vecOut[4], 32'h0404_0404);
        checkOutput("goodReadyLow", 32'(bus.s_ready), 32'd0);

        applyReset();
        buildFrame(8'h01);
        applyStimulus(0, 80, 80, 0);
        checkOutput("badSumErr", 32'(loadErr), 32'd1);
        checkOutput("badSumCnt", 32'(failCnt), 32'd1);
        checkOutput("badSumReset", vecOut[1], 32'h0);
        checkOutput("badSumHold", 32'(cpuHold), 32'd1);
        @(posedge hclk);
        #1 checkOutput("badSumErrPulse", 32'(loadErr), 32'd0);
        buildFrame(8'h00);
        applyStimulus(0, 80, 80, 0);
        checkGoodTable("afterBad");

        applyReset();
        applyStimulus(0, 40, 40, 0);
        checkOutput("shortErr", 32'(loadErr), 32'd1);
        checkOutput("shortCnt", 32'(failCnt), 32'd1);
        checkOutput("shortReady", 32'(bus.s_ready), 32'd1);
        applyStimulus(0, 80, 80, 0);
        checkGoodTable("afterShort");

        applyReset();
        applyStimulus(0, 80, 89, 0);
        checkOutput("longErr", 32'(loadErr), 32'd1);
        checkOutput("longCnt", 32'(failCnt), 32'd1);
        applyStimulus(81, 89, 89, 0);
        checkOutput("drainCnt", 32'(failCnt), 32'd1);
        checkOutput("drainValid", 32'(tableValid), 32'd0);
        checkOutput("drainReady", 32'(bus.s_ready), 32'd1);
        applyStimulus(0, 80, 80, 0);
        checkGoodTable("afterLong");

        applyReset();
        buildFrame(8'h80);
        for (int f = 0; f < 3; f++) applyStimulus(0, 80, 80, 0);
        checkOutput("retryFail", 32'(loadFail), 32'd1);
        checkOutput("retryReady", 32'(bus.s_ready), 32'd0);
        checkOutput("retryHold", 32'(cpuHold), 32'd1);
        checkOutput("retryCnt", 32'(failCnt), 32'd3);
        buildFrame(8'h00);
        errPulses = 0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 81; i++) begin
            bus.s_data = frameBuf[i];
            bus.s_last = (i == 80);
            @(posedge hclk);
            #1 if (loadErr) errPulses++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        checkOutput("ignoredErr", 32'(errPulses), 32'd0);
        checkOutput("ignoredValid", 32'(tableValid), 32'd0);
        checkOutput("ignoredCnt", 32'(failCnt), 32'd3);

        applyReset();
        buildFrame(8'h01);
        applyStimulus(0, 80, 80, 0);
        buildFrame(8'h00);
        applyStimulus(0, 49, 80, 0);
        #2 hreset = 1'b1;
        #1;
        checkOutput("midRstCnt", 32'(failCnt), 32'd0);
        checkOutput("midRstHold", 32'(cpuHold), 32'd1);
        checkOutput("midRstReady", 32'(bus.s_ready), 32'd1);
        checkOutput("midRstValid", 32'(tableValid), 32'd0);
        @(posedge hclk);
        #1 hreset = 1'b0;
        applyStimulus(0, 80, 80, 0);
        checkGoodTable("afterMidRst");

        applyReset();
        applyStimulus(0, 80, 80, 30);
        checkOutput("gapValid", 32'(tableValid), 32'd1);
        for (int i = 0; i < 20; i++)
            checkOutput($sformatf("gapWord%0d", i), vecOut[i], goodWords[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/vec_table_loader.md
Name: vec_table_loader

Overview:
- Upstream feeder of the AHB-lite vector-table slave. Receives the boot vector table as a checksummed byte stream from the root-of-trust key/boot store.
- Drives the 20 vector words (sp, reset, nmi, fault, irq0..irq15) that the slave returns on reads.
- Holds the CPU in reset via cpu_hold until a frame verifies. Escalates to a permanent failure state after MAX_RETRY bad frames.

Parameters:
MAX_RETRY, 3, failed frames (1..15) that force the FAIL state

Ports:
hclk  input  1  clock
hreset  input  1  asynchronous active-high reset
s_valid  input  1  stream byte valid
s_ready  output  1  stream byte ready
s_data  input  8  stream byte
s_last  input  1  marks final byte of frame
sp_addr, reset_addr, nmi_addr, fault_addr  output  32 each  vector words 0..3
irq0_addr..irq15_addr  output  32 each  vector words 4..19
table_valid  output  1  verified table present
cpu_hold  output  1  keep core in reset
load_err  output  1  one-cycle pulse per rejected frame
load_fail  output  1  sticky, retries exhausted
fail_cnt  output  4  rejected frames so far

Behaviour:
- Reset is asynchronous, active-high, and valid at any time, including mid-frame. Reset values:
  - state=LOAD, byte_cnt=0, sum=0, staging regs=0, fail_cnt=0.
  - table_valid=0, cpu_hold=1, load_err=0, load_fail=0, s_ready=1.
- Transfer occurs on each cycle with s_valid & s_ready. s_ready is a registered function of state only (1 in LOAD and DRAIN, 0 in DONE and FAIL). It never depends on s_valid.
- Frame format: exactly 81 bytes.
  - Bytes 0..79 carry 20 little-endian words: word = byte_cnt[6:2], lane = byte_cnt[1:0].
  - Word order is sp, reset, nmi, fault, irq0..irq15.
  - Byte 80 is the checksum: the 8-bit sum of all 81 bytes must be 0.
- Each accepted byte 0..79 writes its staging lane. sum = sum + byte (mod 256). byte_cnt increments.
- States:
  - LOAD:
    - byte 80 accepted, s_last=1, (sum+byte)==0 -> DONE. table_valid=1 and cpu_hold=0 on the next edge.
    - byte 80 accepted, s_last=1, checksum bad -> error.
    - s_last accepted with byte_cnt<80 -> error (short frame).
    - byte 80 accepted without s_last -> error, and go to DRAIN.
  - DRAIN: discard bytes until s_last is accepted, then go to LOAD.
  - DONE: terminal until reset. s_ready=0. Vectors are frozen.
  - FAIL: terminal until reset. s_ready=0, cpu_hold=1, load_fail=1.
- Error action, registered on the same edge as detection:
  - load_err=1 for one cycle; fail_cnt++; byte_cnt=0; sum=0.
  - If the new fail_cnt==MAX_RETRY, go to FAIL. This overrides DRAIN.
  - Otherwise go to LOAD, or to DRAIN for the overlong-frame case.
- Vector outputs equal the staging regs when table_valid=1 and 0 otherwise. Partial or corrupt tables are never visible downstream.
- Latency: table_valid rises 1 cycle after the checksum-byte handshake.
- Back-to-back bytes are accepted every cycle with no bubbles. s_valid gaps are allowed anywhere.

Decomposition:
- Package vec_loader_pkg holds:
  - FRAME_BYTES=81, NUM_VEC=20.
  - Word indices: SP_IDX=0, RESET_IDX=1, NMI_IDX=2, FAULT_IDX=3, IRQ0_IDX=4.
  - One-hot state localparams LOAD, DRAIN, DONE, FAIL.
- Sub-module vec_frame_ctr holds byte_cnt, the checksum accumulator, and the short/long/bad-sum detection. It outputs frame_ok and frame_err.
- The top level holds the FSM, the staging regs and the output gating.

Test Plan:
- Good frame, sp=0x2000_4000, reset=0x0000_0101, irq15=0xDEAD_BEEF, correct checksum:
  - table_valid=1 and cpu_hold=0 one cycle after byte 80.
  - reset_addr=0x0000_0101, irq15_addr=0xDEAD_BEEF.
  - s_ready=0 afterwards.
- Same frame with the checksum byte XOR 0x01:
  - load_err pulse, fail_cnt=1, outputs stay 0, cpu_hold=1.
  - A following good frame then reaches DONE.
- s_last on byte 40:
  - error pulse, fail_cnt=1, state LOAD.
  - The next 81-byte good frame is accepted with correct word alignment.
- 90-byte frame with s_last on the final byte:
  - error at byte 80, DRAIN consumes bytes 81..89, then back to LOAD.
- Three bad frames with MAX_RETRY=3:
  - load_fail=1, s_ready=0, cpu_hold=1, fail_cnt=3.
  - A fourth frame is ignored.
- hreset pulsed at byte 50 of a good frame:
  - all outputs return to their reset values.
  - A fresh frame loads correctly from byte 0.
- Random s_valid gaps (30% idle) on a good frame: final vectors are identical to the gap-free run.
